conv_mac: RTL and testbench

Pipelined multiply-accumulate stage directly downstream of the `conv` window generator. It consumes one 5x5 pixel window per AXI-stream beat and multiplies it element-wise by a programmable signed 5x5 coefficient set. It then sums the 25 products, rounds, shifts and saturates the result, and emits one output pixel per window. `tuser`/`tlast` sideband travels alongside the data unchanged.

---
 rtl/conv_mac.sv | 88 ++++++++
 tb/tb_conv_mac.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_mac.sv
// conv_mac: 4-stage 5x5 signed-coefficient multiply-accumulate with round, shift and saturate on an AXI-stream window
module conv_mac #(
  parameter int PIXEL_W = 8,
  parameter int COEF_W  = 8,
  parameter int SHIFT   = 4
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  s_tvalid_i,
  input  logic [25*PIXEL_W-1:0] s_tdata_i,
  input  logic                  s_tuser_i,
  input  logic                  s_tlast_i,
  output logic                  s_tready_o,
  input  logic                  m_tready_i,
  output logic                  m_tvalid_o,
  output logic [PIXEL_W-1:0]    m_tdata_o,
  output logic                  m_tuser_o,
  output logic                  m_tlast_o,
  input  logic                  coef_we_i,
  input  logic [4:0]            coef_addr_i,
  input  logic [COEF_W-1:0]     coef_dat_i
);
  localparam int PROD_W = PIXEL_W + COEF_W + 1;
  localparam int ACC_W  = PIXEL_W + COEF_W + 6;
  localparam logic signed [COEF_W-1:0] C_RST = COEF_W'(1 << SHIFT);
  localparam logic signed [ACC_W:0]    RND   = (ACC_W+1)'((1 << SHIFT) >> 1);
  localparam logic signed [ACC_W:0]    MAXP  = (ACC_W+1)'((1 << PIXEL_W) - 1);
  logic signed [COEF_W-1:0] c_q [25];
  logic signed [COEF_W-1:0] c_d [25];
  logic signed [PROD_W-1:0] p_q [25];
  logic signed [PROD_W-1:0] p_d [25];
  logic signed [ACC_W-1:0]  r_q [5];
  logic signed [ACC_W-1:0]  r_d [5];
  logic signed [ACC_W-1:0]  a_q, a_d, s;
  logic signed [ACC_W:0]    t, sh;
  logic [PIXEL_W-1:0]       o_q, o_d;
  logic [3:0]               v_q, v_d, u_q, u_d, l_q, l_d;
  logic                     stall;
  always_comb begin
    stall = v_q[3] & ~m_tready_i;
    v_d = stall ? v_q : {v_q[2:0], s_tvalid_i};
    u_d = stall ? u_q : {u_q[2:0], s_tuser_i};
    l_d = stall ? l_q : {l_q[2:0], s_tlast_i};
    for (int i = 0; i < 25; i++) begin
      c_d[i] = (coef_we_i && coef_addr_i == 5'(i)) ? coef_dat_i : c_q[i];
      p_d[i] = stall ? p_q[i] : PROD_W'($signed({1'b0, s_tdata_i[i*PIXEL_W +: PIXEL_W]})) * PROD_W'(c_q[i]);
    end
    for (int k = 0; k < 5; k++) begin
      s = '0;
      for (int j = 0; j < 5; j++) s = s + ACC_W'(p_q[k*5+j]);
      r_d[k] = stall ? r_q[k] : s;
    end
    s = '0;
    for (int k = 0; k < 5; k++) s = s + r_q[k];
    a_d = stall ? a_q : s;
    t = (ACC_W+1)'(a_q) + RND;
    sh = t >>> SHIFT;
    o_d = stall ? o_q : sh[ACC_W] ? '0 : (sh > MAXP) ? PIXEL_W'(MAXP) : sh[PIXEL_W-1:0];
  end
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      for (int i = 0; i < 25; i++) begin
        c_q[i] <= (i == 12) ? C_RST : '0;
        p_q[i] <= '0;
      end
      for (int k = 0; k < 5; k++) r_q[k] <= '0;
      a_q <= '0;
      o_q <= '0;
      v_q <= '0;
      u_q <= '0;
      l_q <= '0;
    end else begin
      c_q <= c_d;
      p_q <= p_d;
      r_q <= r_d;
      a_q <= a_d;
      o_q <= o_d;
      v_q <= v_d;
      u_q <= u_d;
      l_q <= l_d;
    end
  end
  assign s_tready_o = ~stall;
  assign m_tvalid_o = v_q[3];
  assign m_tuser_o  = u_q[3];
  assign m_tlast_o  = l_q[3];
  assign m_tdata_o  = o_q;
endmodule

// File: tb/tb_conv_mac.sv
// tb_conv_mac: randomized self-checking bench for conv_mac against a behavioural filter model
module tb_conv_mac;
  logic clk = 1'b0;
  logic arst = 1'b0;
  logic s_tvalid_i, s_tuser_i, s_tlast_i, s_tready_o, m_tready_i;
  logic m_tvalid_o, m_tuser_o, m_tlast_o, coef_we_i;
  logic [199:0] s_tdata_i;
  logic [7:0] m_tdata_o, coef_dat_i;
  logic [4:0] coef_addr_i;
  int pass_n = 0, tot_n = 0, cyc = 0;
  int coef_m [25];
  logic [9:0] exp_q [$];
  int acc_q [$];
  always #5 clk = ~clk;
  conv_mac dut (
    .clk(clk), .arst(arst),
    .s_tvalid_i(s_tvalid_i), .s_tdata_i(s_tdata_i), .s_tuser_i(s_tuser_i), .s_tlast_i(s_tlast_i),
    .s_tready_o(s_tready_o), .m_tready_i(m_tready_i), .m_tvalid_o(m_tvalid_o), .m_tdata_o(m_tdata_o),
    .m_tuser_o(m_tuser_o), .m_tlast_o(m_tlast_o),
    .coef_we_i(coef_we_i), .coef_addr_i(coef_addr_i), .coef_dat_i(coef_dat_i)
  );
  function automatic logic [7:0] ref_px(input logic [199:0] w);
    int acc = 0;
    for (int i = 0; i < 25; i++) acc += int'(w[i*8 +: 8]) * coef_m[i];
    acc = (acc + 8) >>> 4;
    return acc < 0 ? 8'd0 : acc > 255 ? 8'd255 : 8'(acc);
  endfunction
  task automatic model_reset;
    for (int i = 0; i < 25; i++) coef_m[i] = (i == 12) ? 16 : 0;
    exp_q.delete();
    acc_q.delete();
  endtask
  task automatic do_reset;
    @(negedge clk);
    arst = 1'b1;
    s_tvalid_i = 1'b0;
    coef_we_i = 1'b0;
    m_tready_i = 1'b1;
    model_reset;
    @(negedge clk);
    arst = 1'b0;
  endtask
  task automatic step(input logic sv, input logic [199:0] w, input logic u, input logic l, input logic mr,
                      input logic we, input logic [4:0] a, input logic [7:0] d,
                      output logic popped, output logic [9:0] act, output logic [9:0] ev,
                      output int lat, output logic rdy_ok, output logic took);
    @(negedge clk);
    s_tvalid_i = sv; s_tdata_i = w; s_tuser_i = u; s_tlast_i = l;
    m_tready_i = mr; coef_we_i = we; coef_addr_i = a; coef_dat_i = d;
    #1;
    cyc++;
    popped = 1'b0; act = '0; ev = '0; lat = -1;
    rdy_ok = (s_tready_o === !(m_tvalid_o && !m_tready_i));
    took = sv && s_tready_o;
    if (m_tvalid_o && m_tready_i) begin
      popped = 1'b1;
      act = {m_tuser_o, m_tlast_o, m_tdata_o};
      if (exp_q.size() > 0) begin
        ev = exp_q.pop_front();
        lat = cyc - acc_q.pop_front();
      end else ev = 'x;
    end
    if (took) begin
      exp_q.push_back({u, l, ref_px(w)});
      acc_q.push_back(cyc);
    end
    if (we && a < 25) coef_m[a] = int'($signed(d));
  endtask
  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    logic p, r, tk;
    logic [9:0] x, y;
    int lt;
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1, a, d, p, x, y, lt, r, tk);
  endtask
  task automatic run_one(input logic [199:0] w, output logic [9:0] act, output logic [9:0] ev, output int n);
    logic p, r, tk;
    logic [9:0] a1, e1;
    int lt;
    n = 0; act = '0; ev = '1;
    step(1'b1, w, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 8'd0, p, a1, e1, lt, r, tk);
    for (int k = 0; k < 10; k++) begin
      step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 8'd0, p, a1, e1, lt, r, tk);
      if (p) begin n++; act = a1; ev = e1; end
    end
  endtask
  function automatic logic [199:0] rnd_win(input logic [7:0] centre);
    logic [199:0] w;
    for (int i = 0; i < 25; i++) w[i*8 +: 8] = 8'($urandom);
    w[96 +: 8] = centre;
    return w;
  endfunction
  task automatic test_reset;
    #1 arst = 1'b1;
    #1;
    tot_n++;
    if ({m_tvalid_o, m_tuser_o, m_tlast_o, m_tdata_o} !== 11'd0)
      $display("FAIL reset_outputs got %h want 000", {m_tvalid_o, m_tuser_o, m_tlast_o, m_tdata_o});
    else pass_n++;
    @(negedge clk);
    arst = 1'b0;
    #1;
    tot_n++;
    if (s_tready_o !== 1'b1 || m_tvalid_o !== 1'b0)
      $display("FAIL reset_release got ready=%b valid=%b want ready=1 valid=0", s_tready_o, m_tvalid_o);
    else pass_n++;
  endtask
  task automatic test_passthrough;
    logic [199:0] w;
    logic p, r, tk;
    logic [9:0] act, ev, want;
    int lt, got = 0;
    for (int k = 0; k < 30 && got < 10; k++) begin
      w = {25{8'hFF}};
      w[96 +: 8] = 8'(k);
      step(k < 10, w, k == 0, k == 9, 1'b1, 1'b0, 5'd0, 8'd0, p, act, ev, lt, r, tk);
      if (p) begin
        want = {got == 0, got == 9, 8'(got)};
        tot_n++;
        if (act !== want || act !== ev || lt != 4)
          $display("FAIL passthrough[%0d] got %h lat %0d want %h lat 4", got, act, lt, want);
        else pass_n++;
        got++;
      end
    end
    tot_n++;
    if (got != 10) $display("FAIL passthrough_count got %0d want 10", got);
    else pass_n++;
  endtask
  task automatic test_box;
    logic [9:0] act, ev;
    int n;
    do_reset;
    for (int i = 0; i < 25; i++) wr(5'(i), 8'd1);
    run_one({25{8'd16}}, act, ev, n);
    tot_n++;
    if (n != 1 || act !== 10'd25 || act !== ev) $display("FAIL box got %h n=%0d want 019 n=1", act, n);
    else pass_n++;
  endtask
  task automatic test_saturation;
    logic [9:0] act, ev;
    int n;
    for (int i = 0; i < 25; i++) wr(5'(i), (i == 12) ? 8'd127 : 8'd0);
    run_one(rnd_win(8'd255), act, ev, n);
    tot_n++;
    if (n != 1 || act !== 10'd255 || act !== ev) $display("FAIL sat_high got %h n=%0d want 0ff n=1", act, n);
    else pass_n++;
    wr(5'd12, 8'hFF);
    run_one(rnd_win(8'd200), act, ev, n);
    tot_n++;
    if (n != 1 || act !== 10'd0 || act !== ev) $display("FAIL sat_low got %h n=%0d want 000 n=1", act, n);
    else pass_n++;
  endtask
  task automatic test_backpressure;
    logic [199:0] w;
    logic u, l, mr, we, p, r, tk;
    logic pend = 1'b0, stl = 1'b0;
    logic [4:0] a;
    logic [7:0] d;
    logic [10:0] held = '0;
    logic [9:0] act, ev;
    int lt, sent = 0, got = 0;
    do_reset;
    for (int i = 0; i < 25; i++) wr(5'(i), 8'($urandom));
    for (int k = 0; k < 800 && (sent < 30 || got < sent); k++) begin
      if (!pend && sent < 30 && $urandom_range(3) != 0) begin
        w = rnd_win(8'($urandom));
        u = 1'($urandom);
        l = 1'($urandom);
        pend = 1'b1;
      end
      mr = 1'($urandom);
      we = ($urandom_range(9) == 0);
      a = 5'($urandom);
      d = 8'($urandom);
      step(pend, w, u, l, mr, we, a, d, p, act, ev, lt, r, tk);
      tot_n++;
      if (!r) $display("FAIL bp_ready cyc %0d got %b want %b", cyc, s_tready_o, !(m_tvalid_o && !m_tready_i));
      else pass_n++;
      if (stl) begin
        tot_n++;
        if ({m_tvalid_o, m_tuser_o, m_tlast_o, m_tdata_o} !== held)
          $display("FAIL bp_hold cyc %0d got %h want %h", cyc, {m_tvalid_o, m_tuser_o, m_tlast_o, m_tdata_o}, held);
        else pass_n++;
      end
      stl = m_tvalid_o && !m_tready_i;
      held = {m_tvalid_o, m_tuser_o, m_tlast_o, m_tdata_o};
      if (tk) begin pend = 1'b0; sent++; end
      if (p) begin
        got++;
        tot_n++;
        if (act !== ev) $display("FAIL bp_data[%0d] got %h want %h", got - 1, act, ev);
        else pass_n++;
      end
    end
    tot_n++;
    if (got != 30 || exp_q.size() != 0) $display("FAIL bp_count got %0d left %0d want 30 left 0", got, exp_q.size());
    else pass_n++;
  endtask
  task automatic test_collision;
    logic [199:0] w;
    logic p, r, tk;
    logic [9:0] act, ev;
    logic [9:0] outs [2];
    int lt, n = 0;
    do_reset;
    w = rnd_win(8'd10);
    step(1'b1, w, 1'b1, 1'b0, 1'b1, 1'b1, 5'd12, 8'd32, p, act, ev, lt, r, tk);
    step(1'b1, w, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 8'd0, p, act, ev, lt, r, tk);
    for (int k = 0; k < 10; k++) begin
      step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 8'd0, p, act, ev, lt, r, tk);
      if (p) begin
        tot_n++;
        if (act !== ev) $display("FAIL collision_model[%0d] got %h want %h", n, act, ev);
        else pass_n++;
        if (n < 2) outs[n] = act;
        n++;
      end
    end
    tot_n++;
    if (n != 2 || outs[0] !== {2'b10, 8'd10} || outs[1] !== {2'b01, 8'd20})
      $display("FAIL collision got n=%0d A=%h B=%h want n=2 A=20a B=114", n, outs[0], outs[1]);
    else pass_n++;
  endtask
  task automatic test_mid_reset;
    logic p, r, tk;
    logic [9:0] act, ev;
    int lt, n, seen = 0;
    do_reset;
    for (int k = 0; k < 3; k++) step(1'b1, rnd_win(8'($urandom)), 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 8'd0, p, act, ev, lt, r, tk);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 8'd0, p, act, ev, lt, r, tk);
    @(negedge clk);
    tot_n++;
    if (m_tvalid_o !== 1'b1) $display("FAIL midrst_pre got valid=%b want 1", m_tvalid_o);
    else pass_n++;
    arst = 1'b1;
    #1;
    tot_n++;
    if ({m_tvalid_o, m_tuser_o, m_tlast_o, m_tdata_o} !== 11'd0)
      $display("FAIL midrst_async got %h want 000", {m_tvalid_o, m_tuser_o, m_tlast_o, m_tdata_o});
    else pass_n++;
    model_reset;
    @(negedge clk);
    arst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 8'd0, p, act, ev, lt, r, tk);
      if (m_tvalid_o !== 1'b0) seen++;
    end
    tot_n++;
    if (seen != 0) $display("FAIL midrst_stale got %0d valid cycles want 0", seen);
    else pass_n++;
    run_one(rnd_win(8'd7), act, ev, n);
    tot_n++;
    if (n != 1 || act !== 10'd7 || act !== ev) $display("FAIL midrst_coef got %h n=%0d want 007 n=1", act, n);
    else pass_n++;
  endtask
  initial begin
    s_tvalid_i = 1'b0; s_tdata_i = '0; s_tuser_i = 1'b0; s_tlast_i = 1'b0;
    m_tready_i = 1'b1; coef_we_i = 1'b0; coef_addr_i = '0; coef_dat_i = '0;
    model_reset;
    test_reset;
    test_passthrough;
    test_box;
    test_saturation;
    test_backpressure;
    test_collision;
    test_mid_reset;
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule
